// File: rtl/gpio_cond_pkg.sv
// Shared constants for the GPIO input conditioner.
// The wrapper ties dbnc_limit to GPIO_COND_DBNC_DEFAULT.
package gpio_cond_pkg;

    localparam int GPIO_COND_WIDTH       = 11;
    localparam int GPIO_COND_SYNC_STAGES = 2;
    localparam int GPIO_COND_DBNC_W      = 8;

    localparam logic [GPIO_COND_DBNC_W-1:0] GPIO_COND_DBNC_DEFAULT = 8'd15;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_kind_e;

    function automatic edge_kind_e edge_of(input logic prev, input logic next);
        unique case ({prev, next})
            2'b01:   return EDGE_RISE;
            2'b10:   return EDGE_FALL;
            default: return EDGE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_cond_bit.sv
// One conditioned lane: synchroniser, debounce counter, edge pulses.
// Sticky edge flag present only when GPIO_COND_STICKY_EN is defined.
module gpio_cond_bit
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES = GPIO_COND_SYNC_STAGES,
    parameter int DBNC_W      = GPIO_COND_DBNC_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pad_i,
    input  logic              dbnc_en_i,
    input  logic [DBNC_W-1:0] dbnc_limit_i,
    input  logic              flag_clr_i,
    output logic              sig_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic              flag_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic                   stable_q, stable_d;
    logic [DBNC_W-1:0]      cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    edge_kind_e             edge_k;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    // '>=' keeps a lowered limit from stranding the counter above it
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (!dbnc_en_i) begin
            stable_d = sync_bit;
        end else if (sync_bit != stable_q) begin
            if (cnt_q >= dbnc_limit_i) begin
                stable_d = sync_bit;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        edge_k = edge_of(stable_q, stable_d);
        rise_d = (edge_k == EDGE_RISE);
        fall_d = (edge_k == EDGE_FALL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sig_o  = stable_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef GPIO_COND_STICKY_EN
    logic flag_q, flag_d;

    // a pulse in the same cycle as a clear keeps the flag set
    always_comb begin
        flag_d = rise_q | fall_q | (flag_q & ~flag_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;
`else
    logic unused_clr;
    assign unused_clr = flag_clr_i;
    assign flag_o     = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO pad input conditioner feeding user_proj_timer.io_in.
// Define GPIO_COND_STICKY_EN to build the sticky edge_flag register.
module gpio_in_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int WIDTH       = GPIO_COND_WIDTH,
    parameter int SYNC_STAGES = GPIO_COND_SYNC_STAGES,
    parameter int DBNC_W      = GPIO_COND_DBNC_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [WIDTH-1:0]  pad_in,
    input  logic [WIDTH-1:0]  dbnc_en,
    input  logic [DBNC_W-1:0] dbnc_limit,
    input  logic [WIDTH-1:0]  flag_clr,
    output logic [WIDTH-1:0]  sig_out,
    output logic [WIDTH-1:0]  rise_pulse,
    output logic [WIDTH-1:0]  fall_pulse,
    output logic [WIDTH-1:0]  edge_flag
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gpio_cond_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DBNC_W      (DBNC_W)
        ) u_bit (
            .clk_i        (wb_clk_i),
            .rst_i        (wb_rst_i),
            .pad_i        (pad_in[i]),
            .dbnc_en_i    (dbnc_en[i]),
            .dbnc_limit_i (dbnc_limit),
            .flag_clr_i   (flag_clr[i]),
            .sig_o        (sig_out[i]),
            .rise_o       (rise_pulse[i]),
            .fall_o       (fall_pulse[i]),
            .flag_o       (edge_flag[i])
        );
    end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner (table vectors + hand sequences).
module tb_gpio_in_conditioner;

    localparam int W = 11;
`ifdef GPIO_COND_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam logic [W-1:0] ALL = 11'h7FF;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pad, en, clr;
    logic [7:0]   lim;
    logic [W-1:0] sig, rise, fall, flag;

    int checks   = 0;
    int failures = 0;

    gpio_in_conditioner dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .pad_in     (pad),
        .dbnc_en    (en),
        .dbnc_limit (lim),
        .flag_clr   (clr),
        .sig_out    (sig),
        .rise_pulse (rise),
        .fall_pulse (fall),
        .edge_flag  (flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pad;
        logic [W-1:0] en;
        logic [7:0]   lim;
        logic [W-1:0] sig;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [W-1:0] p, input logic [W-1:0] e,
                       input logic [7:0] l, input logic [W-1:0] s,
                       input logic [W-1:0] r, input logic [W-1:0] f);
        vec_t v;
        v.pad = p; v.en = e; v.lim = l;
        v.sig = s; v.rise = r; v.fall = f;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%03h required=%03h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ef;

        // bypass: lane 3 up then down
        add(0, 0, 0, 0, 0, 0);
        add(11'h008, 0, 0, 0, 0, 0);
        add(11'h008, 0, 0, 0, 0, 0);
        add(11'h008, 0, 0, 11'h008, 11'h008, 0);
        add(11'h008, 0, 0, 11'h008, 0, 0);
        add(0, 0, 0, 11'h008, 0, 0);
        add(0, 0, 0, 11'h008, 0, 0);
        add(0, 0, 0, 0, 0, 11'h008);
        add(0, 0, 0, 0, 0, 0);
        // debounce limit 4: 4-cycle glitch rejected, then held
        add(0, ALL, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(11'h001, ALL, 4, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, ALL, 4, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(11'h001, ALL, 4, 0, 0, 0);
        add(11'h001, ALL, 4, 11'h001, 11'h001, 0);
        for (int i = 0; i < 3; i++) add(11'h001, ALL, 4, 11'h001, 0, 0);
        // independence: lane 7 up, then lane 1 rise + lane 7 fall
        add(11'h081, 0, 4, 11'h001, 0, 0);
        add(11'h081, 0, 4, 11'h001, 0, 0);
        add(11'h081, 0, 4, 11'h081, 11'h080, 0);
        add(11'h081, 0, 4, 11'h081, 0, 0);
        add(11'h003, 0, 4, 11'h081, 0, 0);
        add(11'h003, 0, 4, 11'h081, 0, 0);
        add(11'h003, 0, 4, 11'h003, 11'h002, 11'h080);
        add(11'h003, 0, 4, 11'h003, 0, 0);

        rst = 1'b1; pad = '0; en = '0; clr = '0; lim = '0;
        repeat (3) tick();
        chk("reset sig", sig, 0);
        chk("reset rise", rise, 0);
        chk("reset fall", fall, 0);
        chk("reset flag", flag, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            pad = tbl[i].pad; en = tbl[i].en; lim = tbl[i].lim;
            tick();
            chk($sformatf("vec%0d sig", i), sig, tbl[i].sig);
            chk($sformatf("vec%0d rise", i), rise, tbl[i].rise);
            chk($sformatf("vec%0d fall", i), fall, tbl[i].fall);
        end

        // limit lowered from 200 to 10 after 50 counts: accept next edge
        en = ALL; lim = 8'd200; pad = 11'h023;
        repeat (30) tick();
        chk("lim mid sig", sig, 11'h003);
        repeat (22) tick();
        chk("lim c50 sig", sig, 11'h003);
        chk("lim c50 rise", rise, 0);
        lim = 8'd10;
        tick();
        chk("lim accept sig", sig, 11'h023);
        chk("lim accept rise", rise, 11'h020);
        tick();
        chk("lim after rise", rise, 0);

        // sticky flag on lane 2
        en = '0; clr = ALL;
        tick();
        clr = '0;
        tick();
        chk("flag cleared", flag, 0);
        pad = 11'h027;
        repeat (3) tick();
        chk("l2 rise", rise, 11'h004);
        tick();
        chk("l2 flag set", flag, STICKY ? 11'h004 : 11'h000);
        pad = 11'h023;
        repeat (3) tick();
        chk("l2 fall", fall, 11'h004);
        clr = 11'h004;
        tick();
        chk("l2 set wins", flag, STICKY ? 11'h004 : 11'h000);
        clr = '0;
        tick();
        chk("l2 flag hold", flag, STICKY ? 11'h004 : 11'h000);
        clr = 11'h004;
        tick();
        clr = '0;
        chk("l2 lone clr", flag, 0);
        tick();
        chk("l2 flag stays 0", flag, 0);

        // reset mid-run with all pads high, limit 3
        pad = ALL;
        repeat (4) tick();
        chk("pre-reset sig", sig, ALL);
        en = ALL; lim = 8'd3; rst = 1'b1;
        tick();
        chk("mid reset sig", sig, 0);
        chk("mid reset rise", rise, 0);
        chk("mid reset fall", fall, 0);
        chk("mid reset flag", flag, 0);
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            ef = (STICKY && e >= 7) ? ALL : 11'h000;
            chk($sformatf("rel e%0d rise", e), rise, (e == 6) ? ALL : 11'h000);
            chk($sformatf("rel e%0d sig", e), sig, (e >= 6) ? ALL : 11'h000);
            chk($sformatf("rel e%0d fall", e), fall, 0);
            chk($sformatf("rel e%0d flag", e), flag, ef);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
